// File: rtl/case_4_sdiv_13s_7s_13_seq.sv
// Sequential signed divider: radix-2 restoring, one quotient bit per clock.
// Truncating (toward zero) quotient, remainder signed like the dividend,
// with divide-by-zero and MIN/-1 overflow flags.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | producing one quotient bit per cycle, MSB first
// DONE  | result held on the outputs until out_ready
module case_4_sdiv_13s_7s_13_seq #(
    parameter int din0_WIDTH = 13,
    parameter int din1_WIDTH = 7
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [din0_WIDTH-1:0] dout_quot,
    output logic [din1_WIDTH-1:0] dout_rem,
    output logic                  dout_dbz,
    output logic                  dout_ovf
);
    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int CW = $clog2(W0 + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0] cnt_q, cnt_d;
    // Magnitude of the dividend shifts out at the MSB while quotient bits
    // shift in at the LSB; after W0 steps it holds |quotient|.
    logic [W0-1:0] dvd_q, dvd_d;
    logic [W1-1:0] dvs_q, dvs_d;
    // Partial remainder always stays below |divisor| <= 2^(W1-1), so W1 bits hold it.
    logic [W1-1:0] pr_q, pr_d;
    logic          negq_q, negq_d;
    logic          negr_q, negr_d;
    logic          zdiv_q, zdiv_d;
    logic          oflw_q, oflw_d;

    logic [W0-1:0] quot_q, quot_d;
    logic [W1-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [W1:0]   pr_shift;
    logic          qbit;
    logic [W0-1:0] q_mag;
    logic [W1-1:0] r_mag;
    logic [W0-1:0] a_abs;
    logic [W1-1:0] b_abs;

    assign in_ready  = ap_rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign dout_quot = quot_q;
    assign dout_rem  = rem_q;
    assign dout_dbz  = dbz_q;
    assign dout_ovf  = ovf_q;

    // One restoring step: shift, trial-compare, conditional subtract.
    always_comb begin
        pr_shift = {pr_q, dvd_q[W0-1]};
        qbit     = (pr_shift >= {1'b0, dvs_q});
        q_mag    = {dvd_q[W0-2:0], qbit};
        r_mag    = qbit ? W1'(pr_shift - {1'b0, dvs_q}) : pr_shift[W1-1:0];
        a_abs    = din0[W0-1] ? (~din0 + 1'b1) : din0;
        b_abs    = din1[W1-1] ? (~din1 + 1'b1) : din1;
    end

    // Next-state and datapath update for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zdiv_d  = zdiv_q;
        oflw_d  = oflw_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvd_d   = a_abs;
                    dvs_d   = b_abs;
                    pr_d    = '0;
                    cnt_d   = CW'(W0);
                    negq_d  = din0[W0-1] ^ din1[W1-1];
                    negr_d  = din0[W0-1];
                    zdiv_d  = (din1 == '0);
                    oflw_d  = (din0 == {1'b1, {(W0-1){1'b0}}}) && (din1 == '1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                dvd_d = q_mag;
                pr_d  = r_mag;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    // MIN/-1 needs no special datapath: |q| = 2^(W0-1) reads back as MIN.
                    if (zdiv_q) begin
                        quot_d = '1;
                        rem_d  = '0;
                    end else begin
                        quot_d = negq_q ? (~q_mag + 1'b1) : q_mag;
                        rem_d  = negr_q ? (~r_mag + 1'b1) : r_mag;
                    end
                    dbz_d   = zdiv_q;
                    ovf_d   = oflw_q & ~zdiv_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zdiv_q  <= 1'b0;
            oflw_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zdiv_q  <= zdiv_d;
            oflw_q  <= oflw_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_case_4_sdiv_13s_7s_13_seq.sv
// Testbench for the sequential signed divider: directed cases, stalls,
// mid-operation reset, back-to-back throughput and randomized operands
// against a plain-arithmetic truncating-division model.
module tb_case_4_sdiv_13s_7s_13_seq;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] din0;
    logic [6:0]  din1;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] dout_quot;
    logic [6:0]  dout_rem;
    logic        dout_dbz;
    logic        dout_ovf;

    int total = 0;
    int bad   = 0;

    case_4_sdiv_13s_7s_13_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_quot (dout_quot),
        .dout_rem  (dout_rem),
        .dout_dbz  (dout_dbz),
        .dout_ovf  (dout_ovf)
    );

    always #5 ap_clk = ~ap_clk;

    // Reference: C-style truncating division on plain integers.
    function automatic void ref_div(input logic signed [12:0] a, input logic signed [6:0] b,
                                    output logic [12:0] q, output logic [6:0] r,
                                    output logic z, output logic o);
        int ai;
        int bi;
        ai = a;
        bi = b;
        z = 1'b0;
        o = 1'b0;
        if (bi == 0) begin
            q = 13'h1FFF;
            r = 7'd0;
            z = 1'b1;
        end else if (ai == -4096 && bi == -1) begin
            q = 13'h1000;
            r = 7'd0;
            o = 1'b1;
        end else begin
            q = 13'(ai / bi);
            r = 7'(ai % bi);
        end
    endfunction

    // Drives one operation; returns the observed result and the latency
    // (posedges from handshake to out_valid, -1 on timeout).
    task automatic run_op(input logic [12:0] a, input logic [6:0] b, input int pre,
                          input int rdly, input bit noise,
                          output logic [12:0] q, output logic [6:0] r,
                          output logic z, output logic o, output int lat);
        int n;
        repeat (pre) @(negedge ap_clk);
        @(negedge ap_clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        in_valid = 1'b1;
        din0 = a;
        din1 = b;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                din0 = 13'($urandom);
                din1 = 7'($urandom);
            end
            @(posedge ap_clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        q = dout_quot;
        r = dout_rem;
        z = dout_dbz;
        o = dout_ovf;
        repeat (rdly) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                din0 = 13'($urandom);
                din1 = 7'($urandom);
            end
            @(posedge ap_clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        din0 = '0;
        din1 = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        total++;
        if ({in_ready, out_valid, dout_quot, dout_rem, dout_dbz, dout_ovf} !== '0) begin
            bad++;
            $display("FAIL reset_values: got rdy=%b vld=%b q=%h r=%h z=%b o=%b, want all 0",
                     in_ready, out_valid, dout_quot, dout_rem, dout_dbz, dout_ovf);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic signed [12:0] va [7] = '{13'sd100, -13'sd100, 13'sd100, -13'sd100, -13'sd4096, 13'sd4095, 13'sd55};
        logic signed [6:0]  vb [7] = '{7'sd7, 7'sd7, -7'sd7, -7'sd7, -7'sd1, -7'sd64, 7'sd0};
        logic [12:0] eq [7] = '{13'd14, 13'h1FF2, 13'h1FF2, 13'd14, 13'h1000, 13'h1FC1, 13'h1FFF};
        logic [6:0]  er [7] = '{7'd2, 7'h7E, 7'd2, 7'h7E, 7'd0, 7'd63, 7'd0};
        logic        ez [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        eo [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [12:0] q;
        logic [6:0]  r;
        logic        z;
        logic        o;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], 0, 0, 1'b0, q, r, z, o, lat);
            total++;
            if ({q, r, z, o} !== {eq[i], er[i], ez[i], eo[i]}) begin
                bad++;
                $display("FAIL directed_%0d (%0d/%0d): got q=%h r=%h z=%b o=%b, want q=%h r=%h z=%b o=%b",
                         i, va[i], vb[i], q, r, z, o, eq[i], er[i], ez[i], eo[i]);
            end
            total++;
            if (lat !== 13) begin
                bad++;
                $display("FAIL directed_latency_%0d: got %0d, want 13", i, lat);
            end
        end
    endtask

    task automatic test_hold();
        int n;
        int errs;
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0 = -13'sd100;
        din1 = 7'sd7;
        out_ready = 1'b0;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        total++;
        if (n !== 13) begin
            bad++;
            $display("FAIL hold_latency: got %0d, want 13", n);
        end
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            din0 = 13'($urandom);
            din1 = 7'($urandom);
            @(posedge ap_clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {dout_quot, dout_rem, dout_dbz, dout_ovf} !== {13'h1FF2, 7'h7E, 1'b0, 1'b0})
                errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL hold_stable: got %0d unstable cycles, want 0 (last q=%h r=%h vld=%b rdy=%b)",
                     errs, dout_quot, dout_rem, out_valid, in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] q;
        logic [6:0]  r;
        logic        z;
        logic        o;
        int          lat;
        int          seen;
        run_op(13'sd4095, -7'sd64, 0, 0, 1'b0, q, r, z, o, lat);
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0 = 13'sd100;
        din1 = 7'sd7;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, dout_quot, dout_rem, dout_dbz, dout_ovf} !== '0) begin
            bad++;
            $display("FAIL reset_mid_clear: got rdy=%b vld=%b q=%h r=%h z=%b o=%b, want all 0",
                     in_ready, out_valid, dout_quot, dout_rem, dout_dbz, dout_ovf);
        end
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge ap_clk);
            #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_no_result: got %0d out_valid cycles, want 0", seen);
        end
        run_op(13'sd100, 7'sd7, 0, 0, 1'b0, q, r, z, o, lat);
        total++;
        if ({q, r, z, o} !== {13'd14, 7'd2, 1'b0, 1'b0} || lat !== 13) begin
            bad++;
            $display("FAIL reset_mid_recover: got q=%h r=%h z=%b o=%b lat=%0d, want q=00e r=02 z=0 o=0 lat=13",
                     q, r, z, o, lat);
        end
    endtask

    task automatic test_back_to_back();
        int rise [3];
        int nr;
        int cyc;
        int n;
        logic prev;
        int errs;
        nr = 0;
        cyc = 0;
        prev = 1'b0;
        errs = 0;
        @(negedge ap_clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        din0 = -13'sd1000;
        din1 = 7'sd9;
        while (nr < 3 && cyc < 80) begin
            @(posedge ap_clk);
            #1;
            cyc++;
            if (out_valid && !prev) begin
                rise[nr] = cyc;
                nr++;
                if ({dout_quot, dout_rem, dout_dbz, dout_ovf} !== {13'h1F91, 7'h7F, 1'b0, 1'b0}) errs++;
            end
            prev = out_valid;
        end
        in_valid = 1'b0;
        total++;
        if (nr != 3 || rise[1] - rise[0] != 15 || rise[2] - rise[1] != 15) begin
            bad++;
            $display("FAIL b2b_throughput: got %0d results spacing %0d/%0d, want 3 results spacing 15/15",
                     nr, (nr > 1) ? rise[1] - rise[0] : 0, (nr > 2) ? rise[2] - rise[1] : 0);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL b2b_values: got %0d wrong results, want 0 (want q=1f91 r=7f)", errs);
        end
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic signed [12:0] a;
        logic signed [6:0]  b;
        logic [12:0] q;
        logic [12:0] eq;
        logic [6:0]  r;
        logic [6:0]  er;
        logic        z;
        logic        ez;
        logic        o;
        logic        eo;
        int          lat;
        int          sel;
        for (int i = 0; i < 1500; i++) begin
            a = 13'($urandom);
            b = 7'($urandom);
            sel = $urandom_range(0, 15);
            if (sel == 0) b = 7'sd0;
            if (sel == 1) b = -7'sd1;
            if (sel == 2) a = -13'sd4096;
            if (sel == 3) b = -7'sd64;
            ref_div(a, b, eq, er, ez, eo);
            run_op(a, b, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, q, r, z, o, lat);
            total++;
            if ({q, r, z, o} !== {eq, er, ez, eo}) begin
                bad++;
                $display("FAIL random_%0d (%0d/%0d): got q=%h r=%h z=%b o=%b, want q=%h r=%h z=%b o=%b",
                         i, a, b, q, r, z, o, eq, er, ez, eo);
            end
            total++;
            if (lat !== 13) begin
                bad++;
                $display("FAIL random_latency_%0d: got %0d, want 13", i, lat);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
